// File: rtl/sdram_rw_arbiter_pkg.sv
// Shared types and defaults for the SDRAM read/write arbiter.
package sdram_rw_arbiter_pkg;

    localparam int ADDR_W_DEF = 24;
    localparam int DATA_W_DEF = 32;

    // Which requester currently owns the command slot.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_RD   = 2'd1,
        ARB_WR   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sdram_rw_arbiter_if.sv
// Bundle of requester, return-path and Avalon-MM master signals around the arbiter.
interface sdram_rw_arbiter_if
    import sdram_rw_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    // read requester
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    // write requester
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_gnt;
    // read return
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    // Avalon-MM master
    logic [ADDR_W-1:0] sdaddress;
    logic              sdread;
    logic              sdwrite;
    logic [DATA_W-1:0] sdwritedata;
    logic              sdwaitrequest;
    logic [DATA_W-1:0] sdreaddata;
    logic              sdreaddatavalid;
    // status
    logic [4:0]        outstanding;
    logic              stray_rd;

    // Arbiter side.
    modport master (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  sdwaitrequest, sdreaddata, sdreaddatavalid,
        output rd_gnt, wr_gnt, rd_data, rd_valid,
        output sdaddress, sdread, sdwrite, sdwritedata,
        output outstanding, stray_rd
    );

    // Requesters plus SDRAM controller side.
    modport slave (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output sdwaitrequest, sdreaddata, sdreaddatavalid,
        input  rd_gnt, wr_gnt, rd_data, rd_valid,
        input  sdaddress, sdread, sdwrite, sdwritedata,
        input  outstanding, stray_rd
    );

endinterface

// File: rtl/sdram_rw_arbiter.sv
// Read-priority arbiter sharing one Avalon-MM master between a read and a
// write requester, with bounded bursts, read-credit tracking and a
// one-cycle registered read-return path.
module sdram_rw_arbiter
    import sdram_rw_arbiter_pkg::*;
#(
    parameter int ADDR_W          = ADDR_W_DEF,
    parameter int DATA_W          = DATA_W_DEF,
    parameter int MAX_OUTSTANDING = 16,
    parameter int READ_BURST      = 8,
    parameter int WRITE_BURST     = 4
) (
    input  logic               clk,
    input  logic               reset,
    sdram_rw_arbiter_if.master bus
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int RB_W  = $clog2(READ_BURST + 1);
    localparam int WB_W  = $clog2(WRITE_BURST + 1);

    arb_state_t        state_reg, state_next;
    logic [RB_W-1:0]   rd_cnt_reg, rd_cnt_next;
    logic [WB_W-1:0]   wr_cnt_reg, wr_cnt_next;
    logic [CNT_W-1:0]  credit_reg, credit_next;
    logic              stray_reg, stray_next;
    logic              sdread_reg, sdread_next;
    logic              sdwrite_reg, sdwrite_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [DATA_W-1:0] rd_data_reg;
    logic              rd_valid_reg;

    logic cmd_busy, cmd_done, slot_free, credit_ok;
    logic rd_burst_done, wr_burst_done;
    logic sel_rd, sel_wr, rd_gnt, wr_gnt;

    assign cmd_busy      = sdread_reg | sdwrite_reg;
    assign cmd_done      = cmd_busy & ~bus.sdwaitrequest;
    assign slot_free     = ~cmd_busy | cmd_done;
    assign credit_ok     = (credit_reg < CNT_W'(MAX_OUTSTANDING));
    assign rd_burst_done = (rd_cnt_reg == RB_W'(READ_BURST));
    assign wr_burst_done = (wr_cnt_reg == WB_W'(WRITE_BURST));

    // Owner selection: decided combinationally so a change of owner costs no bubble.
    always_comb begin
        sel_rd = 1'b0;
        sel_wr = 1'b0;
        unique case (state_reg)
            ARB_RD: begin
                // Yield to a waiting write at burst end, or at once when out of credit.
                if (bus.rd_req && !(bus.wr_req && (rd_burst_done || !credit_ok))) sel_rd = 1'b1;
                else if (bus.wr_req)                                                sel_wr = 1'b1;
            end
            ARB_WR: begin
                // Only hand over to reads when a read could actually be granted.
                if (bus.wr_req && !(bus.rd_req && credit_ok && wr_burst_done)) sel_wr = 1'b1;
                else if (bus.rd_req)                                             sel_rd = 1'b1;
            end
            default: begin
                if (bus.rd_req && (credit_ok || !bus.wr_req)) sel_rd = 1'b1;
                else if (bus.wr_req)                          sel_wr = 1'b1;
            end
        endcase
    end

    // Grants; suppressed while reset is held so no transfer pulses leak out.
    always_comb begin
        rd_gnt = ~reset & slot_free & sel_rd & credit_ok;
        wr_gnt = ~reset & slot_free & sel_wr;
    end

    // Next owner state and burst counters; a grant that changes owner counts as the first of the new burst.
    always_comb begin
        state_next  = sel_rd ? ARB_RD : (sel_wr ? ARB_WR : ARB_IDLE);
        rd_cnt_next = '0;
        wr_cnt_next = '0;
        if (state_next == ARB_RD) begin
            if (state_reg != ARB_RD)           rd_cnt_next = rd_gnt ? RB_W'(1) : '0;
            else if (rd_gnt && !rd_burst_done) rd_cnt_next = rd_cnt_reg + RB_W'(1);
            else                               rd_cnt_next = rd_cnt_reg;
        end
        if (state_next == ARB_WR) begin
            if (state_reg != ARB_WR)           wr_cnt_next = wr_gnt ? WB_W'(1) : '0;
            else if (wr_gnt && !wr_burst_done) wr_cnt_next = wr_cnt_reg + WB_W'(1);
            else                               wr_cnt_next = wr_cnt_reg;
        end
    end

    // Read credits: a return with nothing outstanding is stray and does not consume a credit.
    always_comb begin
        credit_next = credit_reg;
        stray_next  = stray_reg;
        if (bus.sdreaddatavalid && credit_reg == '0) begin
            stray_next = 1'b1;
            if (rd_gnt) credit_next = credit_reg + CNT_W'(1);
        end else if (rd_gnt && !bus.sdreaddatavalid) begin
            credit_next = credit_reg + CNT_W'(1);
        end else if (!rd_gnt && bus.sdreaddatavalid) begin
            credit_next = credit_reg - CNT_W'(1);
        end
    end

    // Command slot: reload from the granted requester whenever the slot frees, otherwise hold.
    always_comb begin
        sdread_next  = sdread_reg;
        sdwrite_next = sdwrite_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        if (slot_free) begin
            sdread_next  = rd_gnt;
            sdwrite_next = wr_gnt;
            if (rd_gnt) begin
                addr_next = bus.rd_addr;
            end else if (wr_gnt) begin
                addr_next  = bus.wr_addr;
                wdata_next = bus.wr_data;
            end
        end
    end

    // State, command, credit and return registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ARB_IDLE;
            rd_cnt_reg   <= '0;
            wr_cnt_reg   <= '0;
            credit_reg   <= '0;
            stray_reg    <= 1'b0;
            sdread_reg   <= 1'b0;
            sdwrite_reg  <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rd_cnt_reg   <= rd_cnt_next;
            wr_cnt_reg   <= wr_cnt_next;
            credit_reg   <= credit_next;
            stray_reg    <= stray_next;
            sdread_reg   <= sdread_next;
            sdwrite_reg  <= sdwrite_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            rd_data_reg  <= bus.sdreaddata;
            rd_valid_reg <= bus.sdreaddatavalid;
        end
    end

    assign bus.rd_gnt      = rd_gnt;
    assign bus.wr_gnt      = wr_gnt;
    assign bus.sdread      = sdread_reg;
    assign bus.sdwrite     = sdwrite_reg;
    assign bus.sdaddress   = addr_reg;
    assign bus.sdwritedata = wdata_reg;
    assign bus.rd_data     = rd_data_reg;
    assign bus.rd_valid    = rd_valid_reg;
    assign bus.outstanding = 5'(credit_reg);
    assign bus.stray_rd    = stray_reg;

endmodule

// File: tb/tb_sdram_rw_arbiter.sv
// Directed self-checking bench for sdram_rw_arbiter with a small Avalon slave model.
module tb_sdram_rw_arbiter;
    import sdram_rw_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sdram_rw_arbiter_if bus ();

    sdram_rw_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // slave model controls
    logic        waitreq = 1'b0;
    logic        ret_en  = 1'b1;
    logic        inj_v   = 1'b0;
    logic [31:0] inj_d   = '0;
    logic [1:0]  pipe_v;
    logic [31:0] pipe_d [2];

    // logs
    int          gseq[$];
    logic [31:0] rlog[$];
    logic [23:0] wlog_a[$];
    logic [31:0] wlog_d[$];
    int          both_cnt;
    int          rd_i, wr_i;
    logic [4:0]  max_out;
    int          cyc, sd_first, sd_last, sd_cnt;

    assign bus.sdwaitrequest   = waitreq;
    assign bus.sdreaddatavalid = (pipe_v[1] & ret_en) | inj_v;
    assign bus.sdreaddata      = inj_v ? inj_d : pipe_d[1];

    // Avalon slave: accepted reads return {A5, address} three cycles after grant; writes are logged.
    always @(posedge clk) begin
        if (reset) begin
            pipe_v <= 2'b00;
        end else begin
            pipe_v[0] <= bus.sdread & ~bus.sdwaitrequest;
            pipe_d[0] <= {8'hA5, bus.sdaddress};
            pipe_v[1] <= pipe_v[0];
            pipe_d[1] <= pipe_d[0];
            if (bus.sdwrite && !bus.sdwaitrequest) begin
                wlog_a.push_back(bus.sdaddress);
                wlog_d.push_back(bus.sdwritedata);
            end
        end
    end

    // Return, credit and sdread activity monitor.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!reset) begin
            if (bus.rd_valid) rlog.push_back(bus.rd_data);
            if (bus.outstanding > max_out) max_out = bus.outstanding;
            if (bus.sdread) begin
                if (sd_first < 0) sd_first = cyc;
                sd_last = cyc;
                sd_cnt  = sd_cnt + 1;
            end
        end
    end

    // One cycle of requester behaviour: sample grants mid-cycle, advance to next request after the edge.
    task automatic cycle();
        logic g_r, g_w;
        @(negedge clk);
        g_r = bus.rd_req & bus.rd_gnt;
        g_w = bus.wr_req & bus.wr_gnt;
        if (g_r && g_w) both_cnt++;
        if (g_r) gseq.push_back(1);
        if (g_w) gseq.push_back(2);
        @(posedge clk);
        #1;
        if (g_r) begin
            rd_i++;
            bus.rd_addr = 24'(rd_i * 4);
        end
        if (g_w) begin
            wr_i++;
            bus.wr_addr = 24'h100000 + 24'(wr_i);
            bus.wr_data = 32'hD000_0000 + 32'(wr_i);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        waitreq = 1'b0;
        ret_en  = 1'b1;
        inj_v   = 1'b0;
        inj_d   = '0;
        rd_i = 0;
        wr_i = 0;
        bus.rd_addr = '0;
        bus.wr_addr = 24'h100000;
        bus.wr_data = 32'hD000_0000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        gseq.delete();
        rlog.delete();
        wlog_a.delete();
        wlog_d.delete();
        both_cnt = 0;
        max_out  = '0;
        sd_first = -1;
        sd_last  = -1;
        sd_cnt   = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (bus.sdread !== 1'b0 || bus.sdwrite !== 1'b0) begin
            fails++;
            $display("FAIL reset_cmd: sdread=%b sdwrite=%b expected 0 0", bus.sdread, bus.sdwrite);
        end
        tests++;
        if (bus.sdaddress !== 24'h0 || bus.sdwritedata !== 32'h0) begin
            fails++;
            $display("FAIL reset_bus: addr=%h wdata=%h expected 0 0", bus.sdaddress, bus.sdwritedata);
        end
        tests++;
        if (bus.rd_valid !== 1'b0 || bus.rd_data !== 32'h0) begin
            fails++;
            $display("FAIL reset_ret: rd_valid=%b rd_data=%h expected 0 0", bus.rd_valid, bus.rd_data);
        end
        tests++;
        if (bus.outstanding !== 5'd0 || bus.stray_rd !== 1'b0) begin
            fails++;
            $display("FAIL reset_credit: outstanding=%0d stray=%b expected 0 0", bus.outstanding, bus.stray_rd);
        end
        tests++;
        if (bus.rd_gnt !== 1'b0 || bus.wr_gnt !== 1'b0) begin
            fails++;
            $display("FAIL reset_gnt: rd_gnt=%b wr_gnt=%b expected 0 0", bus.rd_gnt, bus.wr_gnt);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_read_stream();
        int bad;
        do_reset();
        bus.rd_req = 1'b1;
        repeat (20) cycle();
        bus.rd_req = 1'b0;
        tests++;
        if (gseq.size() != 20) begin
            fails++;
            $display("FAIL stream_gnt: %0d grants in 20 cycles, expected 20", gseq.size());
        end
        for (int k = 0; k < 30 && rlog.size() < 20; k++) cycle();
        repeat (2) cycle();
        tests++;
        if (sd_cnt != 20 || sd_last - sd_first != 19) begin
            fails++;
            $display("FAIL stream_sdread: high %0d cycles span %0d, expected 20 span 19", sd_cnt, sd_last - sd_first);
        end
        tests++;
        if (max_out !== 5'd3) begin
            fails++;
            $display("FAIL stream_plateau: max outstanding %0d, expected 3", max_out);
        end
        tests++;
        if (rlog.size() != 20) begin
            fails++;
            $display("FAIL stream_count: %0d rd_valid pulses, expected 20", rlog.size());
        end
        bad = 0;
        for (int k = 0; k < rlog.size(); k++)
            if (rlog[k] !== {8'hA5, 24'(k * 4)}) bad++;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL stream_order: %0d words out of order/wrong, expected 0", bad);
        end
        tests++;
        if (bus.outstanding !== 5'd0 || bus.stray_rd !== 1'b0) begin
            fails++;
            $display("FAIL stream_drain: outstanding=%0d stray=%b expected 0 0", bus.outstanding, bus.stray_rd);
        end
        $display("[TB] test_read_stream: %0d grants, %0d returns", gseq.size(), rlog.size());
    endtask

    task automatic test_rw_fairness();
        int bad;
        do_reset();
        bus.rd_req = 1'b1;
        bus.wr_req = 1'b1;
        repeat (36) cycle();
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        repeat (6) cycle();
        tests++;
        if (gseq.size() != 36) begin
            fails++;
            $display("FAIL fair_count: %0d grants in 36 cycles, expected 36", gseq.size());
        end
        bad = 0;
        for (int k = 0; k < gseq.size(); k++)
            if (gseq[k] != (((k % 12) < 8) ? 1 : 2)) bad++;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL fair_pattern: %0d grants off the 8R/4W pattern, expected 0", bad);
        end
        tests++;
        if (both_cnt != 0) begin
            fails++;
            $display("FAIL fair_both: %0d cycles with both grants, expected 0", both_cnt);
        end
        bad = 0;
        for (int k = 0; k < wlog_a.size(); k++)
            if (wlog_a[k] !== 24'h100000 + 24'(k) || wlog_d[k] !== 32'hD000_0000 + 32'(k)) bad++;
        tests++;
        if (wlog_a.size() != 12 || bad != 0) begin
            fails++;
            $display("FAIL fair_writes: %0d writes with %0d bad, expected 12 with 0", wlog_a.size(), bad);
        end
        $display("[TB] test_rw_fairness: %0d grants, %0d writes", gseq.size(), wlog_a.size());
    endtask

    task automatic test_credit_limit();
        do_reset();
        ret_en = 1'b0;
        bus.rd_req = 1'b1;
        repeat (30) cycle();
        tests++;
        if (gseq.size() != 16 || bus.outstanding !== 5'd16) begin
            fails++;
            $display("FAIL credit_stall: %0d grants outstanding=%0d, expected 16 16", gseq.size(), bus.outstanding);
        end
        inj_d = 32'h5A5A_0001;
        inj_v = 1'b1;
        cycle();
        inj_v = 1'b0;
        repeat (5) cycle();
        bus.rd_req = 1'b0;
        tests++;
        if (gseq.size() != 17 || bus.outstanding !== 5'd16) begin
            fails++;
            $display("FAIL credit_refill: %0d grants outstanding=%0d, expected 17 16", gseq.size(), bus.outstanding);
        end
        tests++;
        if (rlog.size() != 1 || rlog[0] !== 32'h5A5A_0001 || bus.stray_rd !== 1'b0) begin
            fails++;
            $display("FAIL credit_return: %0d returns stray=%b, expected 1 word 5a5a0001 stray 0", rlog.size(), bus.stray_rd);
        end
        $display("[TB] test_credit_limit: %0d grants", gseq.size());
    endtask

    task automatic test_waitrequest();
        int bad_hold, bad_gnt;
        do_reset();
        waitreq = 1'b1;
        bus.wr_req = 1'b1;
        cycle();
        tests++;
        if (gseq.size() != 1) begin
            fails++;
            $display("FAIL wait_first: %0d grants, expected 1", gseq.size());
        end
        bad_hold = 0;
        bad_gnt  = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.sdwrite !== 1'b1 || bus.sdaddress !== 24'h100000 || bus.sdwritedata !== 32'hD000_0000) bad_hold++;
            if (bus.wr_gnt !== 1'b0 || bus.rd_gnt !== 1'b0) bad_gnt++;
            @(posedge clk);
            #1;
        end
        tests++;
        if (bad_hold != 0) begin
            fails++;
            $display("FAIL wait_hold: %0d cycles with command changed, expected 0", bad_hold);
        end
        tests++;
        if (bad_gnt != 0) begin
            fails++;
            $display("FAIL wait_nognt: %0d cycles with a grant, expected 0", bad_gnt);
        end
        waitreq = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.wr_gnt !== 1'b1) begin
            fails++;
            $display("FAIL wait_release: wr_gnt=%b, expected 1", bus.wr_gnt);
        end
        @(posedge clk);
        #1;
        bus.wr_req = 1'b0;
        tests++;
        if (bus.sdwrite !== 1'b1 || bus.sdaddress !== 24'h100001 || bus.sdwritedata !== 32'hD000_0001
            || wlog_a.size() != 1) begin
            fails++;
            $display("FAIL wait_next: sdwrite=%b addr=%h data=%h writes=%0d, expected 1 100001 d0000001 1",
                     bus.sdwrite, bus.sdaddress, bus.sdwritedata, wlog_a.size());
        end
        $display("[TB] test_waitrequest done");
    endtask

    task automatic test_stray();
        do_reset();
        inj_d = 32'hCAFE_0005;
        inj_v = 1'b1;
        @(posedge clk);
        #1;
        inj_v = 1'b0;
        tests++;
        if (bus.stray_rd !== 1'b1 || bus.rd_valid !== 1'b1 || bus.rd_data !== 32'hCAFE_0005 || bus.outstanding !== 5'd0) begin
            fails++;
            $display("FAIL stray_flag: stray=%b valid=%b data=%h outstanding=%0d, expected 1 1 cafe0005 0",
                     bus.stray_rd, bus.rd_valid, bus.rd_data, bus.outstanding);
        end
        @(posedge clk);
        #1;
        tests++;
        if (bus.rd_valid !== 1'b0 || bus.stray_rd !== 1'b1) begin
            fails++;
            $display("FAIL stray_sticky: valid=%b stray=%b, expected 0 1", bus.rd_valid, bus.stray_rd);
        end
        $display("[TB] test_stray done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        waitreq = 1'b1;
        bus.rd_req = 1'b1;
        repeat (3) cycle();
        tests++;
        if (bus.sdread !== 1'b1 || bus.outstanding !== 5'd1 || gseq.size() != 1) begin
            fails++;
            $display("FAIL mid_setup: sdread=%b outstanding=%0d grants=%0d, expected 1 1 1",
                     bus.sdread, bus.outstanding, gseq.size());
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (bus.sdread !== 1'b0 || bus.outstanding !== 5'd0 || dut.state_reg !== ARB_IDLE) begin
            fails++;
            $display("FAIL mid_reset: sdread=%b outstanding=%0d state=%0d, expected 0 0 0",
                     bus.sdread, bus.outstanding, dut.state_reg);
        end
        @(negedge clk);
        tests++;
        if (bus.rd_gnt !== 1'b0) begin
            fails++;
            $display("FAIL mid_nognt: rd_gnt=%b during reset, expected 0", bus.rd_gnt);
        end
        @(posedge clk);
        #1;
        bus.rd_req = 1'b0;
        reset = 1'b0;
        $display("[TB] test_reset_mid done");
    endtask

    initial begin
        bus.rd_req  = 1'b0;
        bus.wr_req  = 1'b0;
        bus.rd_addr = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        both_cnt = 0;
        max_out  = '0;
        cyc      = 0;
        sd_first = -1;
        sd_last  = -1;
        sd_cnt   = 0;
        test_reset();
        test_read_stream();
        test_rw_fairness();
        test_credit_limit();
        test_waitrequest();
        test_stray();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
